// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: operation
// encodings, FSM state encodings and the default operand width.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hi_we;
  logic             lo_we;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
// Optional macro FAST_MUL_EN: multiplies complete via a single-cycle
// combinational product instead of the iterative loop.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int unsigned CYCLES = WIDTH;
  localparam int unsigned CW     = $clog2(CYCLES + 1);
  localparam int unsigned AW     = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [WIDTH:0]   div_rem_sh;
  logic [WIDTH:0]   div_diff;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes and signs; unsigned ops never see a negative operand
  assign a_neg = ~bus.op[0] & bus.operand_a[WIDTH-1];
  assign b_neg = ~bus.op[0] & bus.operand_b[WIDTH-1];
  assign mag_a = a_neg ? (~bus.operand_a + WIDTH'(1)) : bus.operand_a;
  assign mag_b = b_neg ? (~bus.operand_b + WIDTH'(1)) : bus.operand_b;

  // One shift-add step: multiplier in the low half, partial product in the high half
  assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring-divide step: remainder in the high half, quotient shifts in low
  assign div_rem_sh = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff   = div_rem_sh - {1'b0, b_q};
  assign div_next   = div_diff[WIDTH] ? {div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign correction applied when the result is committed
  assign prod_fix = neg_res_q ? (~acc_q + AW'(1)) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[AW-1:WIDTH] + WIDTH'(1)) : acc_q[AW-1:WIDTH];

`ifdef FAST_MUL_EN
  logic [AW-1:0] fast_prod;
  assign fast_prod = AW'(mag_a) * AW'(mag_b);
`endif

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_d       = a_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d    = 1'b1;
          cnt_d     = '0;
          dbz_d     = 1'b0;
          op_d      = bus.op;
          a_d       = bus.operand_a;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          zero_d    = (bus.operand_b == '0);
          state_d   = S_RUN;
          if (bus.op[1]) begin
            acc_d = {WIDTH'(0), mag_a};
            b_d   = mag_b;
          end else begin
            acc_d = {WIDTH'(0), mag_b};
            b_d   = mag_a;
`ifdef FAST_MUL_EN
            acc_d   = fast_prod;
            state_d = S_FIX;
`endif
          end
        end else begin
          if (bus.hi_we) hi_d = bus.operand_a;
          if (bus.lo_we) lo_d = bus.operand_a;
        end
      end
      S_RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CYCLES - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          if (zero_q) begin
            lo_d  = '1;
            hi_d  = a_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
          hi_d = prod_fix[AW-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      a_q       <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_q       <= a_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written sequences
// for register writes, busy-time interference and mid-operation reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   lat;
  int   bcnt;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o);
`ifdef FAST_MUL_EN
    logic [1:0] t;
    t = o;
    return t[1] ? 33 : 1;
`else
    return (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) ? 33 : 0;
`endif
  endfunction

  // Drive a start for one edge; lat counts edges after the start edge
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op        = o;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    lat  = 0;
    bcnt = 0;
  endtask

  task automatic step();
    if (bus.busy) bcnt++;
    @(posedge clk);
    #1;
    lat++;
  endtask

  task automatic wait_done();
    while (!bus.done && lat < 200) step();
  endtask

  initial begin
    logic [1:0] rst_op;
    int         pulses;
    n_cmp = 0;
    n_bad = 0;
    lat   = 0;
    bcnt  = 0;
    rst   = 1'b1;
    bus.start = 1'b0;
    bus.op = OP_MULT;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{OP_DIVU,  32'h00000009, 32'h00000003, 32'h00000000, 32'h00000003, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{OP_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[10] = '{OP_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
    vecs[11] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[13] = '{OP_MULTU, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
    check("rst_hi",   bus.hi, 32'd0);
    check("rst_lo",   bus.lo, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // MTHI / MTLO
    bus.hi_we = 1'b1;
    bus.operand_a = 32'h00001234;
    @(posedge clk);
    #1;
    bus.hi_we = 1'b0;
    check("mthi", bus.hi, 32'h00001234);
    bus.lo_we = 1'b1;
    bus.operand_a = 32'h00005678;
    @(posedge clk);
    #1;
    bus.lo_we = 1'b0;
    check("mtlo", bus.lo, 32'h00005678);
    check("mtlo_hi_kept", bus.hi, 32'h00001234);

    // Start wins over hi_we/lo_we in the same cycle
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    start_op(OP_DIVU, 32'h00000007, 32'h00000002);
    check("start_wins_hi", bus.hi, 32'h00001234);
    check("start_wins_lo", bus.lo, 32'h00005678);
    check("start_busy", 32'(bus.busy), 32'd1);
    wait_done();
    check("sw_lat", 32'(lat), 32'(exp_lat(OP_DIVU)));
    check("sw_lo", bus.lo, 32'h00000003);
    check("sw_hi", bus.hi, 32'h00000001);
    step();
    check("sw_done_width", 32'(bus.done), 32'd0);

    // Vector table; even entries chain straight into the next start on done
    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done();
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vecs[i].op)));
      check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(exp_lat(vecs[i].op)));
      check($sformatf("v%0d_busy_low", i), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
      if (i % 2 == 1) begin
        step();
        check($sformatf("v%0d_done_width", i), 32'(bus.done), 32'd0);
        check($sformatf("v%0d_dbz_sticky", i), 32'(bus.div_by_zero), 32'(vecs[i].dbz));
      end
    end

    // Start and hi_we/lo_we while busy are ignored; hi/lo hold during RUN
    step();
    start_op(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
    repeat (9) step();
    bus.start = 1'b1;
    bus.op = OP_MULTU;
    bus.operand_a = 32'h0000DEAD;
    bus.operand_b = 32'h00000005;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    step();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("busy_ign_hi", bus.hi, vecs[NV-1].hi);
    check("busy_ign_lo", bus.lo, vecs[NV-1].lo);
    check("busy_ign_busy", 32'(bus.busy), 32'd1);
    wait_done();
    check("busy_ign_lat", 32'(lat), 32'd33);
    check("busy_ign_res_hi", bus.hi, 32'hFFFFFFFF);
    check("busy_ign_res_lo", bus.lo, 32'hFFFFFFFD);
    step();
    check("busy_ign_no_restart", 32'(bus.busy), 32'd0);

    // Reset in the middle of an operation
`ifdef FAST_MUL_EN
    rst_op = OP_DIVU;
`else
    rst_op = OP_MULT;
`endif
    start_op(rst_op, 32'h00000003, 32'h00000005);
    repeat (19) step();
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    check("midrst_hi_after", bus.hi, 32'd0);
    check("midrst_busy_after", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
